// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART-side round-robin arbiter: FSM state
// encoding and the width helpers used to size index and burst counters.
package uart_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   // Requester index width; a single requester still needs one bit.
   function automatic int id_width(input int n_req);
      return (clog2(n_req) < 1) ? 1 : clog2(n_req);
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: returns the first asserted request found when
// scanning from ptr upward, wrapping from N_REQ-1 back to 0.
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int ID_W  = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             any,
   output logic [ID_W-1:0]  idx
);

   int pos;

   // Scan offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first;
      // a path that leaves one unassigned would infer a latch.
      any = 1'b0;
      idx = '0;
      pos = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= N_REQ) pos = pos - N_REQ;
         for (int j = 0; j < N_REQ; j++) begin
            if (j == pos && req[j]) begin
               any = 1'b1;
               idx = ID_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/uart_sync_rr_arbiter.sv
// Round-robin arbiter sharing one ready/valid consumer among N_REQ producers.
// A granted producer may send up to MAX_BURST beats; each accepted beat is
// captured in a single output register tagged with the producer's index.
module uart_sync_rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int N_REQ      = 4,
   parameter  int DATA_WIDTH = 8,
   parameter  int MAX_BURST  = 4,
   localparam int ID_W       = id_width(N_REQ),
   localparam int CNT_W      = clog2(MAX_BURST + 1)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            in_valid,
   output logic [N_REQ-1:0]            in_ready,
   input  logic [N_REQ*DATA_WIDTH-1:0] in_d,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       out_d,
   output logic [ID_W-1:0]             out_id,
   output logic                        grant_active,
   output logic [ID_W-1:0]             grant_id
);

   arb_state_t            state, state_nxt;
   logic [ID_W-1:0]       ptr, ptr_nxt, grant_nxt, ptr_wrap;
   logic [CNT_W-1:0]      burst_cnt, cnt_nxt, cnt_inc;
   logic                  pick_any;
   logic [ID_W-1:0]       pick_idx;
   logic                  gnt_valid;
   logic [DATA_WIDTH-1:0] gnt_d;
   logic                  slot_free;
   logic                  accept;

   uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req (in_valid),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Select the granted requester's valid and payload.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_d     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (ID_W'(i) == grant_id) begin
            gnt_valid = in_valid[i];
            gnt_d     = in_d[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign slot_free    = !out_valid || out_ready;
   assign grant_active = (state == ARB_GRANT);
   assign accept       = grant_active && gnt_valid && slot_free;
   assign cnt_inc      = burst_cnt + 1'b1;
   // Explicit wrap keeps ptr in range when N_REQ is not a power of two.
   assign ptr_wrap     = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

   // Ready only to the granted requester, and only when the output slot frees.
   always_comb begin
      in_ready = '0;
      if (grant_active) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_id) in_ready[i] = slot_free;
         end
      end
   end

   // Next-state logic: grant selection, burst counting and release.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = grant_id;
      cnt_nxt   = burst_cnt;
      case (state)
         ARB_IDLE: begin
            if (pick_any) begin
               grant_nxt = pick_idx;
               cnt_nxt   = '0;
               state_nxt = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (!gnt_valid) begin
               state_nxt = ARB_IDLE;
               ptr_nxt   = ptr_wrap;
               cnt_nxt   = '0;
            end else if (slot_free) begin
               if (cnt_inc == CNT_W'(MAX_BURST)) begin
                  state_nxt = ARB_IDLE;
                  ptr_nxt   = ptr_wrap;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      if (reset) begin
         state     <= ARB_IDLE;
         ptr       <= '0;
         grant_id  <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         grant_id  <= grant_nxt;
         burst_cnt <= cnt_nxt;
      end
   end

   // Output register: load on accept, otherwise drain when the consumer takes it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_d     <= '0;
         out_id    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_d     <= gnt_d;
         out_id    <= grant_id;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_sync_rr_arbiter.sv
// Directed bench for uart_sync_rr_arbiter: a 4-requester/4-beat instance
// for grant, burst, backpressure, valid-drop and reset behaviour, plus a
// 3-requester/1-beat instance for round-robin wrap order.
module tb_uart_sync_rr_arbiter;

   logic        clock;
   logic        reset;

   // Instance 1: N_REQ=4, MAX_BURST=4
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [31:0] in_d;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_d;
   logic [1:0]  out_id;
   logic        grant_active;
   logic [1:0]  grant_id;

   // Instance 2: N_REQ=3, MAX_BURST=1
   logic [2:0]  v2;
   logic [2:0]  r2;
   logic [23:0] d2;
   logic        ov2;
   logic        or2;
   logic [7:0]  od2;
   logic [1:0]  oid2;
   logic        ga2;
   logic [1:0]  gid2;

   int n_checks = 0;
   int n_fail   = 0;

   // Producer model for instance 1: requester i sends base[i]+cnt[i] until cnt[i]==lim[i].
   int         cnt [4];
   int         lim [4];
   logic [7:0] base [4];

   int exp_ga [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
   int exp_ov [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
   int exp_od [11] = '{0, 'h10, 'h11, 'h12, 'h13, 0, 'h14, 'h15, 'h16, 'h17, 0};

   uart_sync_rr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_d         (in_d),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_d        (out_d),
      .out_id       (out_id),
      .grant_active (grant_active),
      .grant_id     (grant_id)
   );

   uart_sync_rr_arbiter #(.N_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut_rr3 (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (v2),
      .in_ready     (r2),
      .in_d         (d2),
      .out_valid    (ov2),
      .out_ready    (or2),
      .out_d        (od2),
      .out_id       (oid2),
      .grant_active (ga2),
      .grant_id     (gid2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         in_valid[i]     = (cnt[i] < lim[i]);
         in_d[i*8 +: 8]  = 8'(int'(base[i]) + cnt[i]);
      end
   endtask

   // One clock of instance 1: note handshakes before the edge, advance producers after.
   task automatic cycle();
      logic [3:0] acc;
      #1;
      acc = in_valid & in_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) if (acc[i]) cnt[i]++;
      drive();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cnt[i]  = 0;
         lim[i]  = 0;
         base[i] = 8'h00;
      end
      drive();
      v2 = 3'b000;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = '0;
      in_d      = '0;
      out_ready = 1'b1;
      v2        = '0;
      d2        = {8'hC2, 8'hC1, 8'hC0};
      or2       = 1'b1;

      // ---------------- reset state ----------------
      do_reset();
      check("rst_out_valid", out_valid, 0);
      check("rst_grant_active", grant_active, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_out_d", out_d, 0);

      // ---------------- single requester ----------------
      lim[2] = 1; base[2] = 8'hA5; drive();
      cycle();  // edge 1
      check("single_grant_id", grant_id, 2);
      check("single_grant_active", grant_active, 1);
      check("single_in_ready", in_ready, 4'b0100);
      check("single_out_valid_e1", out_valid, 0);
      cycle();  // edge 2
      check("single_out_d", out_d, 8'hA5);
      check("single_out_id", out_id, 2);
      check("single_out_valid_e2", out_valid, 1);
      cycle();  // edge 3: released, ptr=3
      check("single_release", grant_active, 0);
      lim[0] = 1; lim[3] = 1; base[0] = 8'h70; base[3] = 8'h73; drive();
      cycle();  // edge 4: scan from 3 picks 3 over 0
      check("single_ptr_next", grant_id, 3);

      // ---------------- burst cap ----------------
      do_reset();
      lim[0] = 8; base[0] = 8'h10; drive();
      for (int e = 0; e < 11; e++) begin
         cycle();
         check($sformatf("burst_ga_e%0d", e + 1), grant_active, exp_ga[e]);
         check($sformatf("burst_ov_e%0d", e + 1), out_valid, exp_ov[e]);
         if (exp_ov[e] != 0) begin
            check($sformatf("burst_od_e%0d", e + 1), out_d, exp_od[e]);
            check($sformatf("burst_oid_e%0d", e + 1), out_id, 0);
         end
      end

      // ---------------- backpressure ----------------
      do_reset();
      lim[1] = 8; base[1] = 8'h20; drive();
      repeat (3) cycle();
      check("bp_pre_out_d", out_d, 8'h21);
      out_ready = 1'b0;
      #1;
      check("bp_in_ready_low", in_ready, 0);
      for (int c = 0; c < 5; c++) begin
         cycle();
         check($sformatf("bp_hold_d_%0d", c), out_d, 8'h21);
         check($sformatf("bp_hold_id_%0d", c), out_id, 1);
         check($sformatf("bp_hold_ov_%0d", c), out_valid, 1);
         check($sformatf("bp_hold_rdy_%0d", c), in_ready, 0);
         check($sformatf("bp_hold_ga_%0d", c), grant_active, 1);
      end
      out_ready = 1'b1;
      cycle();
      check("bp_resume_d0", out_d, 8'h22);
      cycle();
      check("bp_resume_d1", out_d, 8'h23);
      check("bp_burst_end", grant_active, 0);
      cycle();
      check("bp_gap_ov", out_valid, 0);
      check("bp_regrant", grant_active, 1);
      check("bp_regrant_id", grant_id, 1);

      // ---------------- valid drop ----------------
      do_reset();
      lim[1] = 2; base[1] = 8'h10;
      lim[2] = 3; base[2] = 8'h30; drive();
      cycle();  // edge 1
      check("drop_grant1", grant_id, 1);
      cycle();  // edge 2
      cycle();  // edge 3: requester 1 has sent 2 beats and lowers valid
      check("drop_last_beat", out_d, 8'h11);
      check("drop_still_granted", grant_active, 1);
      lim[0] = 1; base[0] = 8'h50; drive();
      cycle();  // edge 4: released, ptr=2
      check("drop_released", grant_active, 0);
      check("drop_no_beat", out_valid, 0);
      cycle();  // edge 5: scan from 2 picks 2 over 0
      check("drop_next_grant", grant_id, 2);
      check("drop_next_active", grant_active, 1);

      // ---------------- asynchronous reset mid-burst ----------------
      do_reset();
      lim[2] = 1; base[2] = 8'h50; drive();
      repeat (3) cycle();  // grant 2, one beat, release -> ptr=3
      lim[3] = 4; base[3] = 8'h60; drive();
      cycle();  // grant 3
      cycle();  // first beat loaded
      check("ar_pre_ov", out_valid, 1);
      check("ar_pre_gid", grant_id, 3);
      #3;
      reset = 1'b1;
      #1;
      check("ar_ov", out_valid, 0);
      check("ar_in_ready", in_ready, 0);
      check("ar_ga", grant_active, 0);
      check("ar_out_d", out_d, 0);
      check("ar_gid", grant_id, 0);
      for (int i = 0; i < 4; i++) begin
         cnt[i] = 0;
         lim[i] = 0;
      end
      drive();
      @(negedge clock);
      reset = 1'b0;
      lim[1] = 1; base[1] = 8'h81;
      lim[3] = 1; base[3] = 8'h83; drive();
      cycle();
      check("ar_first_grant", grant_id, 1);

      // ---------------- round-robin wrap, N_REQ=3, MAX_BURST=1 ----------------
      do_reset();
      @(posedge clock);
      #2;
      v2 = 3'b111;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clock);
         #2;
         if (e % 2 == 1) begin
            check($sformatf("rr_gid_e%0d", e), gid2, (e - 1) / 2 % 3);
            check($sformatf("rr_ga_e%0d", e), ga2, 1);
         end else begin
            check($sformatf("rr_ga_e%0d", e), ga2, 0);
            check($sformatf("rr_ov_e%0d", e), ov2, 1);
            check($sformatf("rr_oid_e%0d", e), oid2, (e / 2 - 1) % 3);
            check($sformatf("rr_od_e%0d", e), od2, 8'hC0 + (e / 2 - 1) % 3);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_sync_rr_arbiter.md
# uart_sync_rr_arbiter

Round-robin arbiter that shares one synchronous ready/valid consumer, such as the UART transmit path, among N_REQ synchronous producers. Each producer is typically the synchronous side of an async-to-sync handshake channel. The block grants one requester at a time and lets it send a bounded burst. Each accepted beat lands in a single output register, tagged with its source index.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥1, need not be a power of 2)
- DATA_WIDTH, 8, payload width
- MAX_BURST, 4, maximum beats per grant (≥1)
- ID_W (localparam), max(1, clog2(N_REQ)), width of requester index

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately on assertion
- in_valid  in  N_REQ  per-requester valid
- in_ready  out  N_REQ  per-requester ready, one-hot or zero
- in_d  in  N_REQ*DATA_WIDTH  flattened payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts beat
- out_d  out  DATA_WIDTH  registered payload
- out_id  out  ID_W  index of the requester that produced out_d
- grant_active  out  1  FSM in GRANT
- grant_id  out  ID_W  currently or last granted requester

## Operation
- Registers:
  - state (IDLE/GRANT)
  - ptr (next-priority index)
  - grant_id
  - burst_cnt (clog2(MAX_BURST+1) bits)
  - out_valid, out_d, out_id
- Reset values:
  - state=IDLE, ptr=0, grant_id=0, burst_cnt=0
  - out_valid=0, out_d=0, out_id=0
  - in_ready=0, grant_active=0
- slot_free = !out_valid | out_ready.
- IDLE:
  - in_ready=0.
  - If any in_valid: select the first valid index scanning ptr, ptr+1, … wrapping N_REQ-1→0.
  - Register grant_id=selected, burst_cnt=0, state=GRANT.
  - Else stay in IDLE.
- GRANT:
  - in_ready[grant_id]=slot_free; all other bits 0 (combinational from registers and out_ready).
  - Beat accepted when in_valid[grant_id] & in_ready[grant_id]. On accept: out_d=in_d[grant_id], out_id=grant_id, out_valid=1, burst_cnt+1.
  - Release on an accepted beat that makes burst_cnt==MAX_BURST.
  - Release when in_valid[grant_id]==0 in a GRANT cycle; no beat is taken that cycle.
  - While in_valid[grant_id]==1 and !slot_free: hold grant, no accept, burst_cnt unchanged.
  - On release: state=IDLE, ptr=(grant_id+1) mod N_REQ (explicit wrap, correct for non-power-of-2), burst_cnt=0.
- Output register:
  - out_valid clears on out_valid & out_ready when no new beat loads that cycle.
  - Simultaneous drain and load: new beat replaces the old one, out_valid stays 1.
  - out_d/out_id stable while out_valid & !out_ready.
- Non-granted in_valid is ignored; producers must hold in_valid/in_d until their ready.
- in_valid dropping without a handshake is tolerated: the grant is released, no data is lost.
- Reset mid-burst: in-flight output beat is discarded; after release, arbitration restarts from ptr=0.
- MAX_BURST=1: release after every beat.
- N_REQ=1: ptr stays 0, ID_W=1.

## Timing
- in_valid rises in IDLE:
  - grant at edge 1
  - in_ready high during cycle 1 if slot_free
  - out_valid at edge 2
  - minimum latency 2 cycles.
- Within a grant, with out_ready=1: 1 beat/cycle.
- Grant rotation costs one IDLE cycle: worst-case gap between bursts is 1 dead cycle.
- Fairness: a continuously valid requester is granted within N_REQ-1 other grants, so it waits at most (N_REQ-1)*(MAX_BURST+1) beats+dead cycles, given out_ready=1.
- in_ready has a combinational path from out_ready only; there is no path from in_valid.

## Structure
- Shared package uart_arb_pkg:
  - state constants ARB_IDLE=1'b0, ARB_GRANT=1'b1
  - clog2 function used for ID_W and the burst counter width.
- Sub-module uart_rr_pick: combinational rotating-priority encoder. Inputs: req vector and ptr. Outputs: any, idx. Reusable by other arbiters.
- Top holds the FSM, burst counter and output register.

## Test plan
- Reset: assert reset asynchronously between edges while out_valid=1 → out_valid, in_ready, grant_active drop to 0 before the next edge; after release, first grant follows ptr=0 order.
- Single requester: in_valid[2]=1 with in_d=0xA5, out_ready=1 → grant_id=2 at edge 1, out_d=0xA5, out_id=2, out_valid=1 at edge 2.
- Burst cap: requester 0 always valid, in_d=0x10..0x17, MAX_BURST=4, others idle → beats 0x10–0x13 accepted, one IDLE cycle, then 0x14–0x17.
- Round-robin wrap: N_REQ=3, all valid, MAX_BURST=1 → grant order 0,1,2,0,1,2; out_id follows the same order.
- Backpressure: out_ready=0 for 5 cycles mid-burst → in_ready=0, out_d/out_id frozen, burst_cnt unchanged; out_ready=1 → stream resumes with no loss or duplication.
- Valid drop: granted requester 1 lowers in_valid after 2 of 4 beats → grant released, ptr=2, next grant goes to requester 2 if valid.
